// File: rtl/vector_dot_sequencer_pkg.sv
// Shared constants for the dot-product sequencer: float32 width/zero,
// sequencer FSM encodings and a width helper.
package vector_dot_sequencer_pkg;

  localparam int          FP32_WIDTH = 32;
  localparam logic [31:0] FP32_ZERO  = 32'h0000_0000;
  localparam logic [31:0] FP32_QNAN  = 32'h7fc0_0000;

  localparam logic [1:0] ST_LOAD = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_OUT  = 2'd2;

  // Bits needed to hold values 0..v-1, never less than one bit.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/vector_dot_sequencer_vmul.sv
// Combinational float32 dot product of two packed VLEN-element vectors.
// Round-to-nearest-even, subnormals flushed to zero, NaN/Inf propagated.
module VectorMultiplication
  import vector_dot_sequencer_pkg::*;
#(
  parameter int VLEN = 5
) (
  input  logic [VLEN*FP32_WIDTH-1:0] A,
  input  logic [VLEN*FP32_WIDTH-1:0] B,
  output logic [FP32_WIDTH-1:0]      result
);

  function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic               s, g, st;
    logic [7:0]         ea, eb;
    logic [23:0]        ma, mb, m;
    logic [47:0]        p;
    logic signed [10:0] e;
    logic [24:0]        r;
    s  = a[31] ^ b[31];
    ea = a[30:23];
    eb = b[30:23];
    if ((ea == 8'hff && a[22:0] != 23'h0) || (eb == 8'hff && b[22:0] != 23'h0))
      return FP32_QNAN;
    if (ea == 8'hff || eb == 8'hff)
      return (ea == 8'h00 || eb == 8'h00) ? FP32_QNAN : {s, 8'hff, 23'h0};
    if (ea == 8'h00 || eb == 8'h00)
      return {s, 31'h0};
    ma = {1'b1, a[22:0]};
    mb = {1'b1, b[22:0]};
    p  = ma * mb;
    e  = $signed({3'b000, ea}) + $signed({3'b000, eb}) - 11'sd127;
    if (p[47]) begin
      m  = p[47:24];
      g  = p[23];
      st = |p[22:0];
      e  = e + 11'sd1;
    end else begin
      m  = p[46:23];
      g  = p[22];
      st = |p[21:0];
    end
    r = {1'b0, m} + {24'h0, g & (st | m[0])};
    if (r[24]) begin
      e = e + 11'sd1;
      r = {1'b0, r[24:1]};
    end
    if (e >= 11'sd255) return {s, 8'hff, 23'h0};
    if (e <= 11'sd0)   return {s, 31'h0};
    return {s, e[7:0], r[22:0]};
  endfunction

  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0]        x, y;
    logic [7:0]         d;
    logic [26:0]        ml, ms, msh, m;
    logic [53:0]        sh;
    logic [27:0]        sum;
    logic signed [10:0] e;
    logic [24:0]        r;
    int                 lz;
    if ((a[30:23] == 8'hff && a[22:0] != 23'h0) || (b[30:23] == 8'hff && b[22:0] != 23'h0))
      return FP32_QNAN;
    if (a[30:23] == 8'hff && b[30:23] == 8'hff && a[31] != b[31])
      return FP32_QNAN;
    if (a[30:23] == 8'hff) return a;
    if (b[30:23] == 8'hff) return b;
    if (a[30:23] == 8'h00) return (b[30:23] == 8'h00) ? FP32_ZERO : b;
    if (b[30:23] == 8'h00) return a;
    if (a[30:0] >= b[30:0]) begin
      x = a;
      y = b;
    end else begin
      x = b;
      y = a;
    end
    ml = {1'b1, x[22:0], 3'b000};
    ms = {1'b1, y[22:0], 3'b000};
    d  = x[30:23] - y[30:23];
    if (d > 8'd27) d = 8'd27;
    // Alignment keeps guard/round bits and folds everything below into a sticky bit.
    sh  = {ms, 27'h0} >> d;
    msh = sh[53:27] | {26'h0, |sh[26:0]};
    e   = $signed({3'b000, x[30:23]});
    if (x[31] == y[31]) begin
      sum = {1'b0, ml} + {1'b0, msh};
      if (sum[27]) begin
        m = {sum[27:2], sum[1] | sum[0]};
        e = e + 11'sd1;
      end else begin
        m = sum[26:0];
      end
    end else begin
      sum = {1'b0, ml} - {1'b0, msh};
      if (sum == 28'h0) return FP32_ZERO;
      lz = 0;
      for (int i = 0; i < 27; i++)
        if (sum[i]) lz = 26 - i;
      m = sum[26:0] << lz;
      e = e - $signed(11'(lz));
    end
    r = {1'b0, m[26:3]} + {24'h0, m[2] & ((|m[1:0]) | m[3])};
    if (r[24]) begin
      e = e + 11'sd1;
      r = {1'b0, r[24:1]};
    end
    if (e >= 11'sd255) return {x[31], 8'hff, 23'h0};
    if (e <= 11'sd0)   return {x[31], 31'h0};
    return {x[31], e[7:0], r[22:0]};
  endfunction

  logic [FP32_WIDTH-1:0] acc;

  // NOTE: combinational logic uses blocking '=' so each statement sees the value
  // just computed; acc gets its value first so no latch can be inferred.
  always_comb begin
    acc = FP32_ZERO;
    for (int i = 0; i < VLEN; i++)
      acc = fp_add(acc, fp_mul(A[FP32_WIDTH*i +: FP32_WIDTH], B[FP32_WIDTH*i +: FP32_WIDTH]));
    result = acc;
  end

endmodule

// File: rtl/vector_dot_sequencer.sv
// Serial element-pair loader feeding VectorMultiplication; holds A/B stable,
// waits MULT_LATENCY cycles, then presents one dot product per vector.
module vector_dot_sequencer
  import vector_dot_sequencer_pkg::*;
#(
  parameter int VLEN         = 5,
  parameter int MULT_LATENCY = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_a,
  input  logic [31:0]                in_b,
  input  logic                       in_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_result,
  output logic [clog2(VLEN+1)-1:0]   out_count
);

  localparam int CW = clog2(VLEN + 1);
  localparam int LW = clog2(MULT_LATENCY + 1);

  logic [1:0]                 state;
  logic [CW-1:0]              idx;
  logic [LW-1:0]              cnt;
  logic [FP32_WIDTH-1:0]      a_reg [VLEN];
  logic [FP32_WIDTH-1:0]      b_reg [VLEN];
  logic [VLEN*FP32_WIDTH-1:0] vec_a, vec_b;
  logic [FP32_WIDTH-1:0]      mult_result;
  logic                       accept, last_beat;

  assign in_ready  = (state == ST_LOAD);
  assign out_valid = (state == ST_OUT);
  assign accept    = in_valid && (state == ST_LOAD);
  assign last_beat = in_last || (idx == CW'(VLEN - 1));

  generate
    for (genvar g = 0; g < VLEN; g++) begin : g_pack
      assign vec_a[FP32_WIDTH*g +: FP32_WIDTH] = a_reg[g];
      assign vec_b[FP32_WIDTH*g +: FP32_WIDTH] = b_reg[g];
    end
  endgenerate

  VectorMultiplication #(.VLEN(VLEN)) u_vmul (
    .A      (vec_a),
    .B      (vec_b),
    .result (mult_result)
  );

  // NOTE: the element registers are reset (not left as uninitialised storage)
  // because elements skipped by an early in_last must read as +0.0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_LOAD;
      idx        <= '0;
      cnt        <= '0;
      out_result <= FP32_ZERO;
      out_count  <= '0;
      for (int i = 0; i < VLEN; i++) begin
        a_reg[i] <= FP32_ZERO;
        b_reg[i] <= FP32_ZERO;
      end
    end else begin
      case (state)
        ST_LOAD: begin
          if (accept) begin
            for (int i = 0; i < VLEN; i++) begin
              if (idx == CW'(i)) begin
                a_reg[i] <= in_a;
                b_reg[i] <= in_b;
              end
            end
            idx <= idx + CW'(1);
            if (last_beat) begin
              state     <= ST_WAIT;
              cnt       <= LW'(MULT_LATENCY);
              out_count <= idx + CW'(1);
            end
          end
        end
        ST_WAIT: begin
          if (cnt == '0) begin
            out_result <= mult_result;
            state      <= ST_OUT;
          end else begin
            cnt <= cnt - LW'(1);
          end
        end
        ST_OUT: begin
          if (out_ready) begin
            state <= ST_LOAD;
            idx   <= '0;
            for (int i = 0; i < VLEN; i++) begin
              a_reg[i] <= FP32_ZERO;
              b_reg[i] <= FP32_ZERO;
            end
          end
        end
        default: state <= ST_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_vector_dot_sequencer.sv
// Directed bench for vector_dot_sequencer: load/pack, early last, backpressure,
// bubbles, resets, and result latency for MULT_LATENCY of 0 and 3.
module tb_vector_dot_sequencer;
  import vector_dot_sequencer_pkg::*;

  localparam int VLEN = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0, en3 = 1'b0;
  logic [31:0] in_a = '0, in_b = '0;
  logic        in_ready, out_valid, in_ready3, out_valid3, in_valid3, out_ready3;
  logic [31:0] out_result, out_result3;
  logic [2:0]  out_count, out_count3;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int last_edge = 0;

  real t1a [VLEN] = '{3.2, 0.66, -0.5, -0.5, 2.82};
  real t1b [VLEN] = '{4.2, 0.51, -6.4, 6.4, -0.94};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign in_valid3  = in_valid & en3;
  assign out_ready3 = out_ready & en3;

  vector_dot_sequencer #(.VLEN(VLEN), .MULT_LATENCY(0)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_count(out_count)
  );

  vector_dot_sequencer #(.VLEN(VLEN), .MULT_LATENCY(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid3), .in_ready(in_ready3),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(out_valid3),
    .out_ready(out_ready3), .out_result(out_result3), .out_count(out_count3)
  );

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    int          e;
    if (r == 0.0) return 32'h0;
    d = $realtobits(r);
    e = int'(d[62:52]) - 896;
    return {d[63], e[7:0], d[51:29]} + {31'h0, d[28]};
  endfunction

  function automatic real f2r(input logic [31:0] f);
    logic [10:0] e;
    if (f[30:23] == 8'h0) return 0.0;
    e = {3'b000, f[30:23]} + 11'd896;
    return $bitstoreal({f[31], e, f[22:0], 29'h0});
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_near(input string tag, input logic [31:0] obs, input real exp);
    real err;
    err = (f2r(obs) - exp) / exp;
    if (err < 0.0) err = -err;
    if (!(err < 1.0e-5)) $display("  %s observed %h (%f)", tag, obs, f2r(obs));
    check(tag, {63'h0, err < 1.0e-5}, 64'h1);
  endtask

  task automatic beat(input logic [31:0] a, input logic [31:0] b, input logic last);
    in_a = a; in_b = b; in_last = last; in_valid = 1'b1;
    @(posedge clk);
    last_edge = cyc;
    #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic send_vec(input int n, input bit bubbles);
    for (int i = 0; i < n; i++) begin
      if (bubbles) begin
        @(posedge clk);
        #1;
      end
      beat(r2f(t1a[i]), r2f(t1b[i]), (i == n - 1) && (n < VLEN));
    end
  endtask

  task automatic wait_valid(input bit sel3, input int max, output int edge_idx, output bit ok);
    ok = 1'b0;
    edge_idx = -1;
    for (int i = 0; i < max && !ok; i++) begin
      @(posedge clk);
      #1;
      if (sel3 ? out_valid3 : out_valid) begin
        ok = 1'b1;
        edge_idx = cyc - 1;
      end
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    int  e, e3;
    bit  ok, stable, rdy_low;
    logic [31:0] held;

    #12;
    check("rst_in_ready",   in_ready,   1);
    check("rst_out_valid",  out_valid,  0);
    check("rst_out_result", out_result, 0);
    check("rst_out_count",  out_count,  0);
    check("rst_vec_a",      dut.vec_a,  0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Test 1: full vector
    send_vec(VLEN, 0);
    check("t1_in_ready_wait", in_ready, 0);
    wait_valid(0, 20, e, ok);
    check("t1_timeout", ok, 1);
    check("t1_latency", e, last_edge + 1);
    check_near("t1_result", out_result, 11.1258);
    check("t1_count", out_count, 5);
    check("t1_pack_a2", dut.vec_a[64 +: 32], r2f(-0.5));
    check("t1_pack_b4", dut.vec_b[128 +: 32], r2f(-0.94));
    handshake();
    check("t1_in_ready_after", in_ready, 1);
    check("t1_out_valid_after", out_valid, 0);
    check("t1_cleared", dut.vec_a, 0);

    // Test 2: early in_last on the second pair
    send_vec(2, 0);
    wait_valid(0, 20, e, ok);
    check("t2_timeout", ok, 1);
    check("t2_latency", e, last_edge + 1);
    check_near("t2_result", out_result, 13.7766);
    check("t2_count", out_count, 2);
    check("t2_a_hi_zero", dut.vec_a[159:64], 0);
    check("t2_b_hi_zero", dut.vec_b[159:64], 0);
    handshake();

    // Test 3: backpressure, then all (1.0, 2.0)
    for (int i = 0; i < VLEN; i++) beat(r2f(1.0), r2f(2.0), 1'b0);
    wait_valid(0, 20, e, ok);
    check("t3_timeout", ok, 1);
    held = out_result;
    stable = 1'b1;
    rdy_low = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (!out_valid || out_result !== held || out_count !== 3'd5) stable = 1'b0;
      if (in_ready) rdy_low = 1'b0;
    end
    check("t3_hold_stable", stable, 1);
    check("t3_in_ready_low", rdy_low, 1);
    check("t3_result", out_result, 32'h4120_0000);
    check("t3_count", out_count, 5);
    handshake();
    check("t3_in_ready_next", in_ready, 1);

    // Test 4: bubbles during LOAD, in_valid held in WAIT/OUT
    send_vec(VLEN, 1);
    in_a = r2f(100.0); in_b = r2f(100.0); in_valid = 1'b1;
    wait_valid(0, 20, e, ok);
    check("t4_timeout", ok, 1);
    check_near("t4_result", out_result, 11.1258);
    check("t4_count", out_count, 5);
    repeat (3) @(posedge clk);
    #1;
    handshake();
    in_valid = 1'b0;
    check("t4_idx_zero", dut.idx, 0);
    check("t4_no_extra", dut.vec_a, 0);

    // Test 5: reset mid-LOAD and with out_valid high
    for (int i = 0; i < 3; i++) beat(r2f(100.0), r2f(-7.0), 1'b0);
    rst_n = 1'b0;
    #1;
    check("t5a_out_valid", out_valid, 0);
    check("t5a_in_ready", in_ready, 1);
    check("t5a_idx", dut.idx, 0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_vec(VLEN, 0);
    wait_valid(0, 20, e, ok);
    check("t5b_timeout", ok, 1);
    rst_n = 1'b0;
    #1;
    check("t5b_out_valid", out_valid, 0);
    check("t5b_in_ready", in_ready, 1);
    check("t5b_out_result", out_result, 0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_vec(VLEN, 0);
    wait_valid(0, 20, e, ok);
    check("t5c_timeout", ok, 1);
    check("t5c_latency", e, last_edge + 1);
    check_near("t5c_result", out_result, 11.1258);
    check("t5c_count", out_count, 5);
    handshake();

    // Test 6: MULT_LATENCY 0 and 3 side by side
    en3 = 1'b1;
    send_vec(VLEN, 0);
    wait_valid(0, 20, e, ok);
    check("t6_l0_timeout", ok, 1);
    check("t6_l0_latency", e, last_edge + 1);
    wait_valid(1, 20, e3, ok);
    check("t6_l3_timeout", ok, 1);
    check("t6_l3_latency", e3, last_edge + 4);
    check_near("t6_l3_result", out_result3, 11.1258);
    check("t6_l3_count", out_count3, 5);
    handshake();
    en3 = 1'b0;
    check("t6_l3_in_ready", in_ready3, 1);
    check("t6_l0_in_ready", in_ready, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
